// File: rtl/reg_dump.sv
// Register-file dump sequencer: walks Raddr over all 2**D registers and streams
// {data, index} beats through a 2-entry buffer. Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module reg_dump #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         Start,
  output logic         Busy,
  output logic         Done,
  output logic [D-1:0] Raddr,
  input  logic [W-1:0] RdData,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [W-1:0] OutData,
  output logic [D-1:0] OutAddr,
  output logic         OutLast
);

  typedef struct packed {
    logic [W-1:0] data;
    logic [D-1:0] addr;
    logic         last;
  } beat_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CSUM,
    S_DRAIN
  } state_t;

  localparam logic [D-1:0] LAST_ADDR = {D{1'b1}};

  state_t       state_q, state_d;
  logic [D-1:0] raddr_q, raddr_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  beat_t        head_q, head_d;
  beat_t        tail_q, tail_d;
  logic         head_vld_q, head_vld_d;
  logic         tail_vld_q, tail_vld_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [W-1:0] acc_q, acc_d;
`endif

  logic  push;
  logic  pop;
  beat_t beat_in;

  // Sequencer and buffer next-state
  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
`ifdef REG_DUMP_CHECKSUM_EN
    acc_d      = acc_q;
`endif
    push       = 1'b0;
    beat_in    = '0;
    pop        = head_vld_q && OutReady;

    case (state_q)
      S_IDLE: begin
        raddr_d = '0;
        // A Start landing in the Done cycle is treated as arriving while busy
        if (Start && !done_q) begin
          state_d = S_READ;
          busy_d  = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      S_READ: begin
        if (!tail_vld_q || pop) begin
          push         = 1'b1;
          beat_in.data = RdData;
          beat_in.addr = raddr_q;
          raddr_d      = raddr_q + D'(1);
`ifdef REG_DUMP_CHECKSUM_EN
          beat_in.last = 1'b0;
          acc_d        = acc_q ^ RdData;
          if (raddr_q == LAST_ADDR) state_d = S_CSUM;
`else
          beat_in.last = (raddr_q == LAST_ADDR);
          if (raddr_q == LAST_ADDR) state_d = S_DRAIN;
`endif
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (!tail_vld_q || pop) begin
          push         = 1'b1;
          beat_in.data = acc_q;
          beat_in.addr = '0;
          beat_in.last = 1'b1;
          state_d      = S_DRAIN;
        end
      end
`endif
      S_DRAIN: begin
        if (pop && !tail_vld_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Two-slot FIFO: head feeds the outputs, tail absorbs the push while head is stalled
    case ({push, pop})
      2'b10: begin
        if (!head_vld_q) begin
          head_d     = beat_in;
          head_vld_d = 1'b1;
        end else begin
          tail_d     = beat_in;
          tail_vld_d = 1'b1;
        end
      end
      2'b01: begin
        if (tail_vld_q) head_d = tail_q;
        head_vld_d = tail_vld_q;
        tail_vld_d = 1'b0;
      end
      2'b11: begin
        if (tail_vld_q) begin
          head_d = tail_q;
          tail_d = beat_in;
        end else begin
          head_d = beat_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= S_IDLE;
      raddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Raddr    = raddr_q;
  assign OutValid = head_vld_q;
  assign OutData  = head_q.data;
  assign OutAddr  = head_q.addr;
  assign OutLast  = head_q.last;

endmodule
